pipe_ctrl_n: RTL and testbench

Parametrised pipeline control unit, successor to the fixed 6-bit stall controller used in the MIPS core top. It merges NREQ stall-request sources and one flush source into a per-stage stall vector plus flush/redirect outputs. It also holds instruction SRAM read data across stalls, so ID never loses a fetched word. It tracks consecutive stall cycles for a watchdog and counts total stall cycles for performance.

---
 rtl/pipe_ctrl_n.sv | 123 ++++++++++++
 tb/tb_pipe_ctrl_n.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_n.sv
// pipe_ctrl_n: merges NREQ stall-request sources and a flush source into a
// per-stage stall vector plus flush/redirect. It also holds the fetched
// instruction word across IF stalls so ID never loses it, runs a watchdog on
// consecutive stall cycles, and counts total stall cycles.
//
// Handshake note: there is no valid/ready pair here. Every input is a level
// that is sampled each cycle, and every output is meaningful every cycle.
// new_pc is only significant while flush=1 and reads 0 otherwise.
module pipe_ctrl_n #(
  parameter int                  STAGES    = 6,
  parameter int                  NREQ      = 4,
  parameter logic [3*NREQ-1:0]   REQ_STAGE = {3'd4, 3'd3, 3'd2, 3'd2},
  parameter int                  DATA_W    = 32,
  parameter int                  TIMEOUT   = 255,
  parameter int                  CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stallreq,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  input  logic [DATA_W-1:0] inst_sram_rdata,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic [DATA_W-1:0] inst_out,
  output logic              stall_timeout,
  output logic [31:0]       stall_total,
  output logic              state_dbg,
  output logic [CNT_W-1:0]  stall_cnt_dbg
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_d;
  logic [31:0]        stall_total_q, stall_total_d;
  logic [STAGES-1:0]  stall_raw;

  // Each active source freezes its own stage and every stage upstream of it.
  // A stage index at or beyond the last stage freezes the whole pipe.
  always_comb begin
    stall_raw = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (stallreq[i]) begin
        for (int b = 0; b < STAGES; b++) begin
          if ((b <= int'(REQ_STAGE[3*i +: 3])) ||
              (int'(REQ_STAGE[3*i +: 3]) >= STAGES - 1)) begin
            stall_raw[b] = 1'b1;
          end
        end
      end
    end
  end

  // Flush and reset both override stalls; redirect is only driven on flush.
  always_comb begin
    stall  = (rst || flush_req) ? '0 : stall_raw;
    flush  = !rst && flush_req;
    new_pc = flush ? flush_pc : 32'd0;
  end

  // Hold-buffer next state: capture on entry to HOLD, drop on release or flush.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      RUN: begin
        if (stall[1] && !flush_req) begin
          hold_d  = inst_sram_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (flush_req) begin
          hold_d  = '0;
          state_d = RUN;
        end else if (!stall[1]) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Watchdog and performance counters, both saturating.
  always_comb begin
    cnt_d = '0;
    if (stall[0] && !flush_req) begin
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end
    timeout_d     = (cnt_d >= CNT_W'(TIMEOUT));
    stall_total_d = stall_total_q;
    if (stall[0] && (stall_total_q != 32'hFFFF_FFFF)) begin
      stall_total_d = stall_total_q + 32'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      hold_q        <= '0;
      cnt_q         <= '0;
      stall_timeout <= 1'b0;
      stall_total_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      cnt_q         <= cnt_d;
      stall_timeout <= timeout_d;
      stall_total_q <= stall_total_d;
    end
  end

  assign inst_out      = (state_q == HOLD) ? hold_q : inst_sram_rdata;
  assign stall_total   = stall_total_q;
  assign state_dbg     = state_q;
  assign stall_cnt_dbg = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n: directed scenarios followed by random stimulus.
// A driver pushes expected outputs from a reference model into exp_q and a
// monitor pops and compares them every cycle. A second instance with a 2-bit
// watchdog counter exercises counter saturation.
module tb_pipe_ctrl_n;

  localparam int EW = 116;

  logic        clk;
  logic        rst;
  logic [3:0]  stallreq;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [31:0] rdata;

  logic [5:0]  stall, u2_stall;
  logic        flush, u2_flush;
  logic [31:0] new_pc, u2_new_pc;
  logic [31:0] inst_out, u2_inst_out;
  logic        stall_timeout, u2_timeout;
  logic [31:0] stall_total, u2_total;
  logic        state_dbg, u2_state;
  logic [7:0]  cnt_dbg;
  logic [1:0]  u2_cnt;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] preset_val;

  // reference model state
  logic        m_held;
  logic [31:0] m_hold_data;
  int          m_cnt, m_cnt2;
  logic        m_to, m_to2;
  longint      m_total;
  int          stage_tbl [4] = '{2, 2, 3, 4};

  pipe_ctrl_n #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
    .flush_pc(flush_pc), .inst_sram_rdata(rdata), .stall(stall), .flush(flush),
    .new_pc(new_pc), .inst_out(inst_out), .stall_timeout(stall_timeout),
    .stall_total(stall_total), .state_dbg(state_dbg), .stall_cnt_dbg(cnt_dbg)
  );

  pipe_ctrl_n #(.TIMEOUT(3), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
    .flush_pc(flush_pc), .inst_sram_rdata(rdata), .stall(u2_stall), .flush(u2_flush),
    .new_pc(u2_new_pc), .inst_out(u2_inst_out), .stall_timeout(u2_timeout),
    .stall_total(u2_total), .state_dbg(u2_state), .stall_cnt_dbg(u2_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stall vector as "everything up to the deepest requested stage".
  function automatic logic [5:0] model_stall(input logic [3:0] req);
    int deepest = -1;
    int st;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        st = (stage_tbl[i] > 5) ? 5 : stage_tbl[i];
        if (st > deepest) deepest = st;
      end
    end
    if (deepest < 0) return 6'd0;
    return 6'((1 << (deepest + 1)) - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, push expected outputs, advance model
  task automatic drive(input logic r, input logic [3:0] q, input logic f,
                       input logic [31:0] pc, input logic [31:0] d,
                       input logic preset = 1'b0, input logic [31:0] pv = 32'd0);
    logic [5:0]  st;
    logic        fl;
    logic [31:0] np, inst;
    @(negedge clk);
    rst = r; stallreq = q; flush_req = f; flush_pc = pc; rdata = d;
    if (preset) begin
      preset_val = pv;
      force dut.stall_total_q = preset_val;
      force u2.stall_total_q = preset_val;
      #1;
      release dut.stall_total_q;
      release u2.stall_total_q;
      m_total = longint'(pv);
    end
    st   = (r || f) ? 6'd0 : model_stall(q);
    fl   = !r && f;
    np   = fl ? pc : 32'd0;
    inst = m_held ? m_hold_data : d;
    exp_q.push_back({st, fl, np, inst, m_to, 32'(m_total), m_held, 8'(m_cnt),
                     m_to2, 2'(m_cnt2)});
    if (r) begin
      m_held = 1'b0; m_hold_data = '0; m_cnt = 0; m_cnt2 = 0;
      m_to = 1'b0; m_to2 = 1'b0; m_total = 0;
    end else begin
      // ID keeps the word that was on the bus when IF first froze
      if (!m_held) begin
        if (st[1]) begin m_held = 1'b1; m_hold_data = d; end
      end else if (f) begin
        m_held = 1'b0; m_hold_data = '0;
      end else if (!st[1]) begin
        m_held = 1'b0;
      end
      m_cnt  = st[0] ? ((m_cnt  + 1 > 255) ? 255 : m_cnt  + 1) : 0;
      m_cnt2 = st[0] ? ((m_cnt2 + 1 > 3)   ? 3   : m_cnt2 + 1) : 0;
      m_to   = (m_cnt  >= 4);
      m_to2  = (m_cnt2 >= 3);
      if (st[0] && m_total < 64'hFFFF_FFFF) m_total++;
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stall",         32'(stall),         32'(e[115:110]));
        check("flush",         32'(flush),         32'(e[109]));
        check("new_pc",        new_pc,             e[108:77]);
        check("inst_out",      inst_out,           e[76:45]);
        check("stall_timeout", 32'(stall_timeout), 32'(e[44]));
        check("stall_total",   stall_total,        e[43:12]);
        check("state",         32'(state_dbg),     32'(e[11]));
        check("stall_cnt",     32'(cnt_dbg),       32'(e[10:3]));
        check("u2_timeout",    32'(u2_timeout),    32'(e[2]));
        check("u2_stall_cnt",  32'(u2_cnt),        32'(e[1:0]));
      end
    end
  end

  // stimulus
  initial begin
    logic [3:0] req;
    rst = 1'b1; stallreq = 4'hF; flush_req = 1'b0; flush_pc = '0; rdata = '0;
    m_held = 1'b0; m_hold_data = '0; m_cnt = 0; m_cnt2 = 0;
    m_to = 1'b0; m_to2 = 1'b0; m_total = 0; preset_val = '0;
    @(posedge clk);

    // reset with all requests active, then release
    drive(1, 4'hF, 0, 32'd0, 32'h1111_0000);
    drive(1, 4'hF, 0, 32'd0, 32'h1111_0001);
    drive(0, 4'hF, 0, 32'd0, 32'h1111_0002);
    drive(0, 4'h0, 0, 32'd0, 32'h1111_0003);
    drive(1, 4'h0, 0, 32'd0, 32'h1111_0004);

    // single ID stall for 3 cycles
    drive(0, 4'b0001, 0, 32'd0, 32'h2408_0001);
    drive(0, 4'b0001, 0, 32'd0, 32'hDEAD_BEEF);
    drive(0, 4'b0001, 0, 32'd0, 32'hDEAD_BEEF);
    drive(0, 4'b0000, 0, 32'd0, 32'hDEAD_BEEF);
    drive(0, 4'b0000, 0, 32'd0, 32'h0000_0042);

    // overlapping requests, deepest wins, no gap when one drops
    drive(0, 4'b0101, 0, 32'd0, 32'hAAAA_0001);
    drive(0, 4'b0101, 0, 32'd0, 32'hAAAA_0002);
    drive(0, 4'b0001, 0, 32'd0, 32'hAAAA_0003);
    drive(0, 4'b0000, 0, 32'd0, 32'hAAAA_0004);
    drive(0, 4'b0000, 0, 32'd0, 32'hAAAA_0005);

    // flush while holding, also with a simultaneous request
    drive(0, 4'b0001, 0, 32'd0,          32'hCCCC_0001);
    drive(0, 4'b0001, 0, 32'd0,          32'hCCCC_0002);
    drive(0, 4'b0001, 1, 32'hBFC0_0380,  32'hCCCC_0003);
    drive(0, 4'b0001, 0, 32'd0,          32'hCCCC_0004);
    drive(0, 4'b0000, 0, 32'd0,          32'hCCCC_0005);

    // watchdog: 7 stalled cycles then release
    for (int i = 0; i < 7; i++) drive(0, 4'b0010, 0, 32'd0, $urandom);
    drive(0, 4'b0000, 0, 32'd0, $urandom);
    drive(0, 4'b0000, 0, 32'd0, $urandom);

    // reset mid-HOLD discards the held word
    drive(0, 4'b1000, 0, 32'd0, 32'h5555_0001);
    drive(0, 4'b1000, 0, 32'd0, 32'h5555_0002);
    drive(1, 4'b1000, 0, 32'd0, 32'h5555_0003);
    drive(0, 4'b0000, 0, 32'd0, 32'h5555_0004);

    // saturation of stall_total and of the 2-bit watchdog counter
    drive(0, 4'b0001, 0, 32'd0, $urandom, 1'b1, 32'hFFFF_FFFD);
    for (int i = 0; i < 5; i++) drive(0, 4'b0001, 0, 32'd0, $urandom);
    drive(0, 4'b0000, 0, 32'd0, $urandom);

    // random traffic with persistent requests, rare flush and reset
    req = 4'h0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 79) == 0), req, ($urandom_range(0, 19) == 0),
            $urandom, $urandom);
    end

    // let the monitor drain
    repeat (3) @(negedge clk);
    #3;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
